// File: rtl/target_locate_if.sv
// rtl/target_locate_if.sv - pixel-stream and result bundle for target_locate
//
// Purpose: groups the binarized pixel stream (vsync / de / bin) and the
// located-target result (centre coordinates, valid pulse, found level).
// Ports (signals):
//   pre_frame_vsync  frame sync, rising edge marks a frame boundary
//   pre_frame_de     active-pixel enable
//   pre_bin          binarized pixel, 1 = target colour
//   x_coor, y_coor   target centre column / row (10 bits)
//   coor_valid_flag  one-cycle pulse, new coordinates available
//   obj_found        level, last completed frame contained a valid target
// Modports: master = pixel source / result consumer, slave = target_locate.

interface target_locate_if;
   logic       pre_frame_vsync;
   logic       pre_frame_de;
   logic       pre_bin;
   logic [9:0] x_coor;
   logic [9:0] y_coor;
   logic       coor_valid_flag;
   logic       obj_found;

   modport master (
      output pre_frame_vsync, pre_frame_de, pre_bin,
      input  x_coor, y_coor, coor_valid_flag, obj_found
   );

   modport slave (
      input  pre_frame_vsync, pre_frame_de, pre_bin,
      output x_coor, y_coor, coor_valid_flag, obj_found
   );
endinterface

// File: rtl/target_locate.sv
// rtl/target_locate.sv - per-frame bounding-box centre of a binarized target
//
// Purpose: accumulates the bounding box and pixel count of target-colour
// pixels over one frame, then on the next vsync rising edge reports the box
// centre (coor_valid_flag pulse two cycles after the edge) when the frame
// held at least MIN_PIXELS target pixels.
// Ports:
//   clk    pixel clock, all logic on the rising edge
//   rst_n  asynchronous active-low reset
//   bus    target_locate_if.slave (pixel stream in, result out)
// Parameters: MIN_PIXELS (valid-target pixel threshold),
//             H_MAX (column/row counter saturation value).
// Optional build macro: TARGET_LOCATE_FILTER_EN - when defined, reported
// coordinates are the rounded mean of the previous report and the new centre.

module target_locate #(
   parameter logic [18:0] MIN_PIXELS = 19'd50,
   parameter logic [9:0]  H_MAX      = 10'd1023
) (
   input  logic            clk,
   input  logic            rst_n,
   target_locate_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, ACCUM, CALC, OUT} state_t;

   state_t      state;
   logic        vs_d;
   logic        de_d;
   logic [9:0]  h_cnt;
   logic [9:0]  v_cnt;
   logic [18:0] pix_cnt;
   logic [9:0]  x_min, x_max, y_min, y_max;

   // snapshot of the finished frame, taken on the vsync edge
   logic [18:0] lat_pix;
   logic [9:0]  lat_x_min, lat_x_max, lat_y_min, lat_y_max;

   logic [9:0]  x_coor_r, y_coor_r;
   logic        valid_r, found_r;

   logic        vs_rise;
   logic        de_fall;
   logic        hit;
   logic [9:0]  centre_x, centre_y;

   assign vs_rise = bus.pre_frame_vsync & ~vs_d;
   assign de_fall = de_d & ~bus.pre_frame_de;
   // pixels coinciding with the vsync edge belong to no frame
   assign hit     = (state == ACCUM) & bus.pre_frame_de & bus.pre_bin & ~vs_rise;

   assign centre_x = 10'(({1'b0, lat_x_min} + {1'b0, lat_x_max}) >> 1);
   assign centre_y = 10'(({1'b0, lat_y_min} + {1'b0, lat_y_max}) >> 1);

   assign bus.x_coor          = x_coor_r;
   assign bus.y_coor          = y_coor_r;
   assign bus.coor_valid_flag = valid_r;
   assign bus.obj_found       = found_r;

   // edge-detect delays and pixel position counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vs_d  <= 1'b0;
         de_d  <= 1'b0;
         h_cnt <= 10'd0;
         v_cnt <= 10'd0;
      end else begin
         vs_d <= bus.pre_frame_vsync;
         de_d <= bus.pre_frame_de;
         if (bus.pre_frame_de) begin
            if (h_cnt != H_MAX)
               h_cnt <= h_cnt + 10'd1;
         end else if (de_fall) begin
            h_cnt <= 10'd0;
         end
         if (vs_rise)
            v_cnt <= 10'd0;
         else if (de_fall && v_cnt != H_MAX)
            v_cnt <= v_cnt + 10'd1;
      end
   end

   // running statistics; cleared on every vsync edge regardless of state so a
   // frame that starts during CALC/OUT still begins from a clean box
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pix_cnt <= 19'd0;
         x_min   <= 10'h3FF;
         x_max   <= 10'd0;
         y_min   <= 10'h3FF;
         y_max   <= 10'd0;
      end else if (vs_rise) begin
         pix_cnt <= 19'd0;
         x_min   <= 10'h3FF;
         x_max   <= 10'd0;
         y_min   <= 10'h3FF;
         y_max   <= 10'd0;
      end else if (hit) begin
         if (pix_cnt != 19'h7FFFF)
            pix_cnt <= pix_cnt + 19'd1;
         if (h_cnt < x_min) x_min <= h_cnt;
         if (h_cnt > x_max) x_max <= h_cnt;
         if (v_cnt < y_min) y_min <= v_cnt;
         if (v_cnt > y_max) y_max <= v_cnt;
      end
   end

`ifdef TARGET_LOCATE_FILTER_EN
   logic        have_prev;
   logic [9:0]  filt_x, filt_y;

   assign filt_x = have_prev ? 10'(({1'b0, x_coor_r} + {1'b0, centre_x} + 11'd1) >> 1) : centre_x;
   assign filt_y = have_prev ? 10'(({1'b0, y_coor_r} + {1'b0, centre_y} + 11'd1) >> 1) : centre_y;
`endif

   // frame FSM with registered outputs; outputs are loaded on the CALC->OUT
   // edge so the valid pulse is high during OUT, two cycles after the vsync edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         lat_pix   <= 19'd0;
         lat_x_min <= 10'h3FF;
         lat_x_max <= 10'd0;
         lat_y_min <= 10'h3FF;
         lat_y_max <= 10'd0;
         x_coor_r  <= 10'd0;
         y_coor_r  <= 10'd0;
         valid_r   <= 1'b0;
         found_r   <= 1'b0;
`ifdef TARGET_LOCATE_FILTER_EN
         have_prev <= 1'b0;
`endif
      end else begin
         valid_r <= 1'b0;
         case (state)
            IDLE: begin
               if (vs_rise)
                  state <= ACCUM;
            end
            ACCUM: begin
               if (vs_rise) begin
                  lat_pix   <= pix_cnt;
                  lat_x_min <= x_min;
                  lat_x_max <= x_max;
                  lat_y_min <= y_min;
                  lat_y_max <= y_max;
                  state     <= CALC;
               end
            end
            CALC: begin
               if (lat_pix >= MIN_PIXELS) begin
`ifdef TARGET_LOCATE_FILTER_EN
                  x_coor_r  <= filt_x;
                  y_coor_r  <= filt_y;
                  have_prev <= 1'b1;
`else
                  x_coor_r  <= centre_x;
                  y_coor_r  <= centre_y;
`endif
                  valid_r   <= 1'b1;
                  found_r   <= 1'b1;
               end else begin
                  found_r   <= 1'b0;
               end
               state <= OUT;
            end
            OUT: begin
               state <= ACCUM;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_target_locate.sv
// tb/tb_target_locate.sv - directed table-driven bench for target_locate

module tb_target_locate;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic vsync = 1'b0;
   logic de = 1'b0;
   logic bin = 1'b0;

   always #5 clk = ~clk;

   target_locate_if if0 ();
   target_locate_if if1 ();

   assign if0.pre_frame_vsync = vsync;
   assign if0.pre_frame_de    = de;
   assign if0.pre_bin         = bin;
   assign if1.pre_frame_vsync = vsync;
   assign if1.pre_frame_de    = de;
   assign if1.pre_bin         = bin;

   target_locate dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
   target_locate #(.MIN_PIXELS(19'd1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

   typedef struct {
      int x0, x1, y0, y1;
      int cols, rows;
      int cx, cy;
      bit ok0;
   } vec_t;

   vec_t tbl[5];

   int checks = 0;
   int errors = 0;

   int  mx[2];
   int  my[2];
   bit  mhave[2];
   bit  mfound[2];

   logic [3:0] p0, p1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   function automatic int filt(input int prev, input int c, input bit have);
`ifdef TARGET_LOCATE_FILTER_EN
      return have ? (prev + c + 1) >> 1 : c;
`else
      return c;
`endif
   endfunction

   task automatic draw_frame(input int x0, x1, y0, y1, cols, rows);
      for (int r = 0; r < rows; r++) begin
         for (int c = 0; c < cols; c++) begin
            de  = 1'b1;
            bin = (c >= x0 && c <= x1 && r >= y0 && r <= y1);
            tick();
         end
         de  = 1'b0;
         bin = 1'b0;
         tick();
         tick();
      end
   endtask

   // raises vsync and records coor_valid_flag after each of the next 4 edges
   task automatic vsync_obs(output logic [3:0] q0, output logic [3:0] q1);
      vsync = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (i == 2) vsync = 1'b0;
         tick();
         q0[i] = if0.coor_valid_flag;
         q1[i] = if1.coor_valid_flag;
      end
   endtask

   task automatic model_frame(input int k, input bit ok, input int cx, input int cy);
      if (ok) begin
         mx[k]     = filt(mx[k], cx, mhave[k]);
         my[k]     = filt(my[k], cy, mhave[k]);
         mhave[k]  = 1'b1;
         mfound[k] = 1'b1;
      end else begin
         mfound[k] = 1'b0;
      end
   endtask

   task automatic check_outputs(input string tag, input bit ok0, input bit ok1);
      check({tag, " dut0 pulse"}, int'(p0), ok0 ? 4'b0010 : 4'b0000);
      check({tag, " dut0 x"}, int'(if0.x_coor), mx[0]);
      check({tag, " dut0 y"}, int'(if0.y_coor), my[0]);
      check({tag, " dut0 found"}, int'(if0.obj_found), int'(mfound[0]));
      check({tag, " dut1 pulse"}, int'(p1), ok1 ? 4'b0010 : 4'b0000);
      check({tag, " dut1 x"}, int'(if1.x_coor), mx[1]);
      check({tag, " dut1 y"}, int'(if1.y_coor), my[1]);
      check({tag, " dut1 found"}, int'(if1.obj_found), int'(mfound[1]));
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         mx[k] = 0; my[k] = 0; mhave[k] = 1'b0; mfound[k] = 1'b0;
      end
   endtask

   initial begin
      // x0, x1, y0, y1, cols, rows, cx, cy, ok0
      tbl[0] = '{100, 109, 50, 59,  112, 60,  104, 54, 1'b1};  // 100 px
      tbl[1] = '{100, 105,  0,  4,  110,  5,  102,  2, 1'b0};  // 30 px
      tbl[2] = '{196, 205,  0,  9,  208, 10,  200,  4, 1'b1};  // 100 px
      tbl[3] = '{  0,   0,  0,  0,    3,  2,    0,  0, 1'b0};  // single px
      tbl[4] = '{1000, 1099, 0, 1, 1100,  2, 1011,  0, 1'b1};  // saturating row

      model_reset();
      rst_n = 1'b0;
      tick(); tick(); tick();
      check("reset x", int'(if0.x_coor), 0);
      check("reset y", int'(if0.y_coor), 0);
      check("reset valid", int'(if0.coor_valid_flag), 0);
      check("reset found", int'(if0.obj_found), 0);
      rst_n = 1'b1;
      tick();

      // partial frame while IDLE: discarded
      draw_frame(100, 109, 0, 9, 112, 10);
      vsync_obs(p0, p1);
      check_outputs("discard", 1'b0, 1'b0);

      for (int i = 0; i < 5; i++) begin
         draw_frame(tbl[i].x0, tbl[i].x1, tbl[i].y0, tbl[i].y1, tbl[i].cols, tbl[i].rows);
         vsync_obs(p0, p1);
         model_frame(0, tbl[i].ok0, tbl[i].cx, tbl[i].cy);
         model_frame(1, 1'b1, tbl[i].cx, tbl[i].cy);
         check_outputs($sformatf("vec%0d", i), tbl[i].ok0, 1'b1);
      end

      // reset mid-frame: outputs clear asynchronously, statistics discarded
      draw_frame(10, 19, 0, 9, 22, 3);
      rst_n = 1'b0;
      #1;
      check("async rst x", int'(if0.x_coor), 0);
      check("async rst y", int'(if0.y_coor), 0);
      check("async rst found", int'(if0.obj_found), 0);
      check("async rst dut1 found", int'(if1.obj_found), 0);
      tick(); tick(); tick();
      rst_n = 1'b1;
      model_reset();
      draw_frame(10, 19, 0, 9, 22, 4);
      vsync_obs(p0, p1);
      check_outputs("post-rst first vsync", 1'b0, 1'b0);
      draw_frame(10, 19, 0, 9, 22, 10);
      vsync_obs(p0, p1);
      model_frame(0, 1'b1, 14, 4);
      model_frame(1, 1'b1, 14, 4);
      check_outputs("post-rst frame", 1'b1, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/target_locate.md
TARGET_LOCATE -- requirements
Module: target_locate

Interface
REQ-001 Parameter MIN_PIXELS, default 19'd50, minimum matched-pixel count per frame for a valid target.
REQ-002 Parameter H_MAX, default 10'd1023, column/row counter saturation value.
REQ-003 clk  input  1  pixel clock (lcd_clk domain); all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 pre_frame_vsync  input  1  frame sync; rising edge = frame boundary.
REQ-006 pre_frame_de  input  1  active-pixel enable.
REQ-007 pre_bin  input  1  binarized pixel, 1 = target colour; sampled only when pre_frame_de=1.
REQ-008 x_coor  output  10  target centre column.
REQ-009 y_coor  output  10  target centre row.
REQ-010 coor_valid_flag  output  1  one-cycle pulse, new x_coor/y_coor available.
REQ-011 obj_found  output  1  level, last completed frame contained a valid target.

Function
REQ-012 FSM states IDLE, ACCUM, CALC, OUT; IDLE->ACCUM on first vsync rising edge, ACCUM->CALC on vsync rising edge, CALC->OUT next cycle, OUT->ACCUM next cycle.
REQ-013 Vsync edge detect: vs_rise = pre_frame_vsync & ~vs_d, vs_d a one-cycle delayed register.
REQ-014 Column counter h_cnt increments each cycle de=1, clears on de falling edge, saturates at H_MAX.
REQ-015 Row counter v_cnt increments on each de falling edge, clears on vs_rise, saturates at H_MAX.
REQ-016 In ACCUM, each de=1 & pre_bin=1 cycle: pix_cnt+1 (19 bits, saturating); x_min/x_max/y_min/y_max updated with h_cnt/v_cnt.
REQ-017 Bounds cleared on vs_rise: mins to 10'h3FF, maxes to 0, pix_cnt to 0; the old values are latched into the CALC stage the same cycle.
REQ-018 CALC: centre_x = (x_min + x_max) >> 1, centre_y = (y_min + y_max) >> 1, 11-bit sum, result truncated to 10 bits.
REQ-019 OUT: if latched pix_cnt >= MIN_PIXELS, register new coords, coor_valid_flag=1 one cycle, obj_found=1; else coords hold, no pulse, obj_found=0.
REQ-020 Latency: vs_rise at cycle N -> coor_valid_flag high at cycle N+2 only.
REQ-021 Pixels with de=1 in the vs_rise cycle are ignored.
REQ-022 In IDLE no statistics accumulate; first partial frame after reset never produces output.
REQ-023 vs_rise while in CALC or OUT is not possible with legal timing; if it occurs, FSM completes OUT and the new frame's statistics start from the cleared state.

Reset
REQ-024 rst_n=0 asynchronously: state IDLE, x_coor=0, y_coor=0, coor_valid_flag=0, obj_found=0, all counters 0, mins 10'h3FF, maxes 0, vs_d=0.
REQ-025 Reset mid-frame discards all accumulated statistics; next output follows the second vsync rising edge after release.

Configuration
REQ-026 Macro TARGET_LOCATE_FILTER_EN defined: on valid frame, x_coor = (x_coor_prev + centre_x + 1) >> 1 (same for y), first valid frame after reset loads centre directly; latency unchanged.
REQ-027 Macro TARGET_LOCATE_FILTER_EN undefined: x_coor/y_coor = centre directly, no filter registers present.

Verification
REQ-028 Reset release, frame 1 discarded; frame 2 with target cols 100-109, rows 50-59 (100 px) -> x_coor=104, y_coor=54, coor_valid_flag single pulse at vs_rise+2, obj_found=1.
REQ-029 Next frame with 30 target px -> no pulse, x_coor=104, y_coor=54 held, obj_found=0.
REQ-030 MIN_PIXELS=1, single target px at col 0, row 0 -> x_coor=0, y_coor=0, pulse.
REQ-031 rst_n low for 3 cycles mid-frame -> all outputs 0 immediately; no pulse at next vs_rise; valid pulse after following frame.
REQ-032 FILTER_EN defined: frame centres 104 then 200 (x) -> x_coor 104 then 152; undefined -> 104 then 200.
REQ-033 Target spanning cols 1000-1023 with row length 1100 -> h_cnt saturates, x_coor=1011, no wrap.
